pipeline_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It consumes the load-use and branch-hazard stall requests (`stcl_lw`, `stcl_jmp`) from hazard detection, together with bus-busy, divider-busy and exception-flush requests. From these it drives the enable and clear of the PC and of every inter-stage register (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It sequences exception redirects so that a PC redirect is never issued while an instruction fetch is still in flight, and it counts stalled cycles for performance monitoring.

---
 rtl/pipeline_stall_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Drives PC and stage-register enables/clears and sequences exception redirects.
module pipeline_stall_ctrl #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stcl_lw,
  input  logic                 stcl_jmp,
  input  logic                 ibus_busy,
  input  logic                 div_busy,
  input  logic                 dbus_busy,
  input  logic                 exc_flush,
  input  logic [PC_WIDTH-1:0]  exc_pc,
  output logic                 PC_en,
  output logic                 IF_ID_en,
  output logic                 ID_EXE_en,
  output logic                 EXE_MEM_en,
  output logic                 MEM_WB_en,
  output logic                 IF_ID_clr,
  output logic                 ID_EXE_clr,
  output logic                 EXE_MEM_clr,
  output logic                 MEM_WB_clr,
  output logic                 redirect_valid,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] WAIT_IBUS = 2'd1;
  localparam logic [1:0] REDIRECT  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       accept;

  assign accept = (state == RUN) && exc_flush;

  always_comb begin
    state_nx       = state;
    PC_en          = 1'b1;
    IF_ID_en       = 1'b1;
    ID_EXE_en      = 1'b1;
    EXE_MEM_en     = 1'b1;
    MEM_WB_en      = 1'b1;
    IF_ID_clr      = 1'b0;
    ID_EXE_clr     = 1'b0;
    EXE_MEM_clr    = 1'b0;
    MEM_WB_clr     = 1'b0;
    redirect_valid = 1'b0;
    if (!rst_n) begin
      PC_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EXE_en   = 1'b0;
      EXE_MEM_en  = 1'b0;
      MEM_WB_en   = 1'b0;
      IF_ID_clr   = 1'b1;
      ID_EXE_clr  = 1'b1;
      EXE_MEM_clr = 1'b1;
      MEM_WB_clr  = 1'b1;
    end else begin
      case (state)
        WAIT_IBUS: begin
          PC_en       = 1'b0;
          IF_ID_en    = 1'b0;
          ID_EXE_en   = 1'b0;
          EXE_MEM_en  = 1'b0;
          MEM_WB_en   = 1'b0;
          IF_ID_clr   = 1'b1;
          ID_EXE_clr  = 1'b1;
          EXE_MEM_clr = 1'b1;
          MEM_WB_clr  = 1'b1;
          if (!ibus_busy)
            state_nx = REDIRECT;
        end
        REDIRECT: begin
          redirect_valid = 1'b1;
          IF_ID_en       = 1'b0;
          ID_EXE_en      = 1'b0;
          EXE_MEM_en     = 1'b0;
          MEM_WB_en      = 1'b0;
          IF_ID_clr      = 1'b1;
          ID_EXE_clr     = 1'b1;
          EXE_MEM_clr    = 1'b1;
          MEM_WB_clr     = 1'b1;
          state_nx       = RUN;
        end
        default: begin
          state_nx = RUN;
          // Priority order: flush beats every stall, deeper stalls beat shallower.
          if (exc_flush) begin
            PC_en       = 1'b0;
            IF_ID_clr   = 1'b1;
            ID_EXE_clr  = 1'b1;
            EXE_MEM_clr = 1'b1;
            MEM_WB_clr  = 1'b1;
            state_nx    = ibus_busy ? WAIT_IBUS : REDIRECT;
          end else if (dbus_busy) begin
            PC_en      = 1'b0;
            IF_ID_en   = 1'b0;
            ID_EXE_en  = 1'b0;
            EXE_MEM_en = 1'b0;
            MEM_WB_clr = 1'b1;
          end else if (div_busy) begin
            PC_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EXE_en   = 1'b0;
            EXE_MEM_clr = 1'b1;
          end else if (stcl_lw || stcl_jmp) begin
            PC_en      = 1'b0;
            IF_ID_en   = 1'b0;
            ID_EXE_clr = 1'b1;
          end else if (ibus_busy) begin
            PC_en     = 1'b0;
            IF_ID_clr = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      redirect_pc <= '0;
      stall_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        redirect_pc <= exc_pc;
      if (!PC_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl.
// Counter is built 4 bits wide so saturation is reachable quickly.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stcl_lw, stcl_jmp, ibus_busy, div_busy, dbus_busy, exc_flush;
  logic [31:0] exc_pc;
  logic        PC_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en;
  logic        IF_ID_clr, ID_EXE_clr, EXE_MEM_clr, MEM_WB_clr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [3:0]  stall_cnt;
  logic [8:0]  ctl;

  int total = 0;
  int bad   = 0;

  localparam logic [8:0] NOM   = 9'b11111_0000;
  localparam logic [8:0] LW    = 9'b00111_0100;
  localparam logic [8:0] DIV   = 9'b00011_0010;
  localparam logic [8:0] DBUS  = 9'b00001_0001;
  localparam logic [8:0] IBUS  = 9'b01111_1000;
  localparam logic [8:0] FLUSH = 9'b01111_1111;
  localparam logic [8:0] HOLD  = 9'b00000_1111;

  pipeline_stall_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .stcl_lw(stcl_lw), .stcl_jmp(stcl_jmp),
    .ibus_busy(ibus_busy), .div_busy(div_busy),
    .dbus_busy(dbus_busy), .exc_flush(exc_flush),
    .exc_pc(exc_pc),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EXE_en(ID_EXE_en),
    .EXE_MEM_en(EXE_MEM_en), .MEM_WB_en(MEM_WB_en),
    .IF_ID_clr(IF_ID_clr), .ID_EXE_clr(ID_EXE_clr),
    .EXE_MEM_clr(EXE_MEM_clr), .MEM_WB_clr(MEM_WB_clr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {PC_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en,
                IF_ID_clr, ID_EXE_clr, EXE_MEM_clr, MEM_WB_clr};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lw, jmp, ib, dv, db, ex,
                       input logic [31:0] pc);
    stcl_lw   = lw;
    stcl_jmp  = jmp;
    ibus_busy = ib;
    div_busy  = dv;
    dbus_busy = db;
    exc_flush = ex;
    exc_pc    = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    chk("rst_ctl", 32'(ctl), 32'(HOLD));
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    tick();
    tick();
    chk("rst_cnt_hold", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    #1;

    drive(0, 0, 0, 0, 0, 0, 32'h0);
    chk("idle_ctl", 32'(ctl), 32'(NOM));
    tick();
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    chk("lw_ctl", 32'(ctl), 32'(LW));
    chk("lw_cnt0", 32'(stall_cnt), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    chk("lw_after", 32'(ctl), 32'(NOM));
    chk("lw_cnt1", 32'(stall_cnt), 32'd1);
    tick();

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 1, 0, 32'h0);
      chk("dbus_ctl", 32'(ctl), 32'(DBUS));
      tick();
    end
    drive(0, 0, 0, 1, 0, 0, 32'h0);
    chk("dbus_cnt", 32'(stall_cnt), 32'd4);
    chk("div_ctl", 32'(ctl), 32'(DIV));
    tick();
    drive(0, 0, 1, 0, 0, 0, 32'h0);
    chk("ibus_ctl", 32'(ctl), 32'(IBUS));
    tick();

    drive(0, 0, 0, 0, 1, 1, 32'hBFC00380);
    chk("exc_ctl", 32'(ctl), 32'(FLUSH));
    chk("exc_rv0", 32'(redirect_valid), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    chk("redir_rv", 32'(redirect_valid), 32'd1);
    chk("redir_pc", redirect_pc, 32'hBFC00380);
    chk("redir_pcen", 32'(PC_en), 32'd1);
    chk("redir_clr", 32'(ctl[3:0]), 32'hF);
    chk("redir_cnt", 32'(stall_cnt), 32'd7);
    tick();
    chk("post_rv", 32'(redirect_valid), 32'd0);
    chk("post_ctl", 32'(ctl), 32'(NOM));
    tick();

    drive(0, 0, 1, 0, 0, 1, 32'hAAAA0000);
    chk("exc2_ctl", 32'(ctl), 32'(FLUSH));
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 1)
        drive(1, 1, 1, 1, 1, 1, 32'h1234);
      else
        drive(0, 0, 1, 0, 0, 0, 32'h0);
      chk("wait_ctl", 32'(ctl), 32'(HOLD));
      chk("wait_rv", 32'(redirect_valid), 32'd0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    chk("fall_ctl", 32'(ctl), 32'(HOLD));
    chk("fall_rv", 32'(redirect_valid), 32'd0);
    tick();
    chk("redir2_rv", 32'(redirect_valid), 32'd1);
    chk("redir2_pc", redirect_pc, 32'hAAAA0000);
    chk("redir2_cnt", 32'(stall_cnt), 32'd13);
    tick();
    chk("post2_rv", 32'(redirect_valid), 32'd0);
    chk("post2_pc", redirect_pc, 32'hAAAA0000);
    tick();

    drive(0, 0, 1, 0, 0, 1, 32'h5555_0000);
    tick();
    chk("wait3_ctl", 32'(ctl), 32'(HOLD));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", 32'(ctl), 32'(HOLD));
    chk("arst_pc", redirect_pc, 32'd0);
    chk("arst_cnt", 32'(stall_cnt), 32'd0);
    chk("arst_rv", 32'(redirect_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("arst_norv", 32'(redirect_valid), 32'd0);
      chk("arst_nom", 32'(ctl), 32'(NOM));
      tick();
    end

    drive(1, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 14; i++)
      tick();
    chk("sat_m1", 32'(stall_cnt), 32'd14);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat", 32'(stall_cnt), 32'd15);
    end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
